// File: rtl/traffic_lanes.sv
// traffic_lanes: lane-based traffic generator for the frog game.
// Each lane is an occupancy ring that rotates once every (slow+1) base ticks.
// The base tick period shrinks with the level down to a fixed floor.
// The bit under a queried cell is registered for the collision logic.
module traffic_lanes #(
    parameter int                              NUM_LANES    = 12,
    parameter int                              LANE_WIDTH   = 20,
    parameter logic [23:0]                     BASE_PERIOD  = 24'd4_000_000,
    parameter logic [23:0]                     SPEED_STEP   = 24'd150_000,
    parameter logic [23:0]                     MIN_PERIOD   = 24'd500_000,
    parameter logic [NUM_LANES-1:0]            LANE_DIR     = {NUM_LANES{1'b1}},
    parameter logic [NUM_LANES*2-1:0]          LANE_SLOW    = '0,
    parameter logic [NUM_LANES*LANE_WIDTH-1:0] LANE_PATTERN = '0
) (
    input  logic                              i_Clk,
    input  logic                              i_Rst_n,
    input  logic [4:0]                        i_Level,
    input  logic                              i_Enable,
    input  logic                              i_Load,
    input  logic [3:0]                        i_Query_Lane,
    input  logic [4:0]                        i_Query_Col,
    output logic                              o_Hit,
    output logic                              o_Step,
    output logic [NUM_LANES*LANE_WIDTH-1:0]   o_Occupancy
);

    localparam int OCC_BITS = NUM_LANES * LANE_WIDTH;

    logic [29:0]         level_cost;
    logic [29:0]         period_wide;
    logic [23:0]         period;
    logic [23:0]         period_last;
    logic [23:0]         cnt;
    logic                tick;
    logic [1:0]          sub      [NUM_LANES];
    logic [1:0]          sub_next [NUM_LANES];
    logic [OCC_BITS-1:0] occ;
    logic [OCC_BITS-1:0] occ_next;
    logic                hit_next;
    logic                step;
    logic                hit;

    // Period from the live level; underflow or anything below the floor clamps to the floor.
    // The >= compare lets a shrinking period fire on the next cycle instead of wrapping.
    always_comb begin
        level_cost  = 30'(i_Level) * 30'(SPEED_STEP);
        period_wide = 30'(BASE_PERIOD) - level_cost;
        if ((level_cost > 30'(BASE_PERIOD)) || (period_wide < 30'(MIN_PERIOD))) begin
            period = MIN_PERIOD;
        end else begin
            period = 24'(period_wide);
        end
        period_last = period - 24'd1;
        tick        = i_Enable && (cnt >= period_last);
    end

    // On a base tick each lane either advances its sub-counter or rotates one cell and restarts.
    always_comb begin
        occ_next = occ;
        for (int i = 0; i < NUM_LANES; i++) begin
            sub_next[i] = sub[i];
            if (tick) begin
                if (sub[i] == LANE_SLOW[i*2 +: 2]) begin
                    sub_next[i] = 2'd0;
                    if (LANE_DIR[i]) begin
                        occ_next[i*LANE_WIDTH +: LANE_WIDTH] =
                            {occ[i*LANE_WIDTH +: LANE_WIDTH-1], occ[i*LANE_WIDTH + LANE_WIDTH - 1]};
                    end else begin
                        occ_next[i*LANE_WIDTH +: LANE_WIDTH] =
                            {occ[i*LANE_WIDTH], occ[i*LANE_WIDTH + 1 +: LANE_WIDTH-1]};
                    end
                end else begin
                    sub_next[i] = sub[i] + 2'd1;
                end
            end
        end
    end

    // Cell lookup for the hit query; out-of-range lanes or columns match nothing and read as 0.
    always_comb begin
        hit_next = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int c = 0; c < LANE_WIDTH; c++) begin
                if ((i_Query_Lane == 4'(l)) && (i_Query_Col == 5'(c))) begin
                    hit_next = occ[l*LANE_WIDTH + c];
                end
            end
        end
    end

    // State registers: reset and load restore the pattern; disable freezes everything but the query.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            occ  <= LANE_PATTERN;
            cnt  <= 24'd0;
            step <= 1'b0;
            hit  <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                sub[i] <= 2'd0;
            end
        end else if (i_Load) begin
            occ  <= LANE_PATTERN;
            cnt  <= 24'd0;
            step <= 1'b0;
            hit  <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                sub[i] <= 2'd0;
            end
        end else begin
            hit <= hit_next;
            if (!i_Enable) begin
                step <= 1'b0;
            end else begin
                occ  <= occ_next;
                step <= tick;
                cnt  <= tick ? 24'd0 : cnt + 24'd1;
                for (int i = 0; i < NUM_LANES; i++) begin
                    sub[i] <= sub_next[i];
                end
            end
        end
    end

    assign o_Hit       = hit;
    assign o_Step      = step;
    assign o_Occupancy = occ;

endmodule

// File: tb/tb_traffic_lanes.sv
// tb_traffic_lanes: scenario tasks plus randomized traffic against a reference model.
// The model tracks only ticks since the last load; lane contents are the pattern
// rotated by ticks/(slow+1) positions, computed with modular arithmetic.
module tb_traffic_lanes;

    localparam int          P_BASE    = 10;
    localparam int          P_STEP    = 2;
    localparam int          P_MIN     = 3;
    localparam logic [1:0]  P_DIR     = 2'b01;
    localparam logic [3:0]  P_SLOW    = 4'b0100;
    localparam logic [15:0] P_PATTERN = {8'b1000_0001, 8'b0000_0011};

    logic        clk;
    logic        rst_n;
    logic [4:0]  level;
    logic        en;
    logic        load;
    logic [3:0]  q_lane;
    logic [4:0]  q_col;
    logic        hit;
    logic        step;
    logic [15:0] occ;

    int checks;
    int passed;

    int m_cnt;
    int m_ticks;
    logic m_step;
    logic m_hit;

    traffic_lanes #(
        .NUM_LANES   (2),
        .LANE_WIDTH  (8),
        .BASE_PERIOD (24'd10),
        .SPEED_STEP  (24'd2),
        .MIN_PERIOD  (24'd3),
        .LANE_DIR    (P_DIR),
        .LANE_SLOW   (P_SLOW),
        .LANE_PATTERN(P_PATTERN)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_n     (rst_n),
        .i_Level     (level),
        .i_Enable    (en),
        .i_Load      (load),
        .i_Query_Lane(q_lane),
        .i_Query_Col (q_col),
        .o_Hit       (hit),
        .o_Step      (step),
        .o_Occupancy (occ)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something stalls outside the bounded waits.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int model_period(input logic [4:0] lvl);
        int p;
        p = P_BASE - int'(lvl) * P_STEP;
        if (p < P_MIN) p = P_MIN;
        return p;
    endfunction

    function automatic logic [15:0] model_occ(input int ticks);
        logic [15:0] pat;
        logic [3:0]  slow_bits;
        logic [1:0]  dir_bits;
        logic [15:0] res;
        int steps;
        int src;
        pat       = P_PATTERN;
        slow_bits = P_SLOW;
        dir_bits  = P_DIR;
        res       = '0;
        for (int l = 0; l < 2; l++) begin
            steps = (ticks / (int'(slow_bits[l*2 +: 2]) + 1)) % 8;
            for (int c = 0; c < 8; c++) begin
                if (dir_bits[l]) src = (c - steps + 8) % 8;
                else             src = (c + steps) % 8;
                res[l*8 + c] = pat[l*8 + src];
            end
        end
        return res;
    endfunction

    function automatic logic model_hit(input int ticks, input logic [3:0] ln, input logic [4:0] cl);
        logic [15:0] cur;
        if (ln >= 4'd2 || cl >= 5'd8) return 1'b0;
        cur = model_occ(ticks);
        return cur[int'(ln) * 8 + int'(cl)];
    endfunction

    // Reference model: counts cycles toward the next tick and the ticks since load.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt   <= 0;
            m_ticks <= 0;
            m_step  <= 1'b0;
            m_hit   <= 1'b0;
        end else begin
            m_hit <= load ? 1'b0 : model_hit(m_ticks, q_lane, q_col);
            if (load) begin
                m_cnt   <= 0;
                m_ticks <= 0;
                m_step  <= 1'b0;
            end else if (!en) begin
                m_step <= 1'b0;
            end else if (m_cnt >= model_period(level) - 1) begin
                m_cnt   <= 0;
                m_ticks <= m_ticks + 1;
                m_step  <= 1'b1;
            end else begin
                m_cnt  <= m_cnt + 1;
                m_step <= 1'b0;
            end
        end
    end

    task automatic wait_step(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (step === 1'b1) return;
            if (n >= 200) begin
                n = -1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        int n;
        rst_n = 1'b0; en = 1'b1; level = 5'd0; load = 1'b0; q_lane = 4'd0; q_col = 5'd0;
        repeat (3) @(negedge clk);
        checks++; if (occ !== 16'h8103) $display("[TB] FAIL reset_occ: got %h expected %h", occ, 16'h8103); else passed++;
        checks++; if (step !== 1'b0) $display("[TB] FAIL reset_step: got %b expected 0", step); else passed++;
        checks++; if (hit !== 1'b0) $display("[TB] FAIL reset_hit: got %b expected 0", hit); else passed++;
        rst_n = 1'b1;
        wait_step(n);
        checks++; if (n !== 10) $display("[TB] FAIL first_tick_delay: got %0d expected 10", n); else passed++;
        checks++; if (occ !== 16'h8106) $display("[TB] FAIL first_tick_occ: got %h expected %h", occ, 16'h8106); else passed++;
        wait_step(n);
        checks++; if (n !== 10) $display("[TB] FAIL second_tick_delay: got %0d expected 10", n); else passed++;
        checks++; if (occ !== 16'hC00C) $display("[TB] FAIL second_tick_occ: got %h expected %h", occ, 16'hC00C); else passed++;
        checks++; if (occ !== model_occ(m_ticks)) $display("[TB] FAIL second_tick_model: got %h expected %h", occ, model_occ(m_ticks)); else passed++;
    endtask

    task automatic test_level_scaling;
        int n;
        level = 5'd2;
        wait_step(n);
        checks++; if (n !== 6) $display("[TB] FAIL level2_spacing_a: got %0d expected 6", n); else passed++;
        wait_step(n);
        checks++; if (n !== 6) $display("[TB] FAIL level2_spacing_b: got %0d expected 6", n); else passed++;
        level = 5'd10;
        wait_step(n);
        checks++; if (n !== 3) $display("[TB] FAIL level10_floor_a: got %0d expected 3", n); else passed++;
        wait_step(n);
        checks++; if (n !== 3) $display("[TB] FAIL level10_floor_b: got %0d expected 3", n); else passed++;
        level = 5'd0;
        repeat (8) @(negedge clk);
        checks++; if (step !== 1'b0) $display("[TB] FAIL level_raise_pre: got %b expected 0", step); else passed++;
        level = 5'd4;
        wait_step(n);
        checks++; if (n !== 1) $display("[TB] FAIL level_raise_next: got %0d expected 1", n); else passed++;
        wait_step(n);
        checks++; if (n !== 3) $display("[TB] FAIL level_raise_after: got %0d expected 3", n); else passed++;
    endtask

    task automatic test_freeze;
        int n;
        int step_seen;
        int occ_moved;
        logic [15:0] snap;
        level = 5'd0;
        repeat (4) @(negedge clk);
        snap = occ;
        step_seen = 0;
        occ_moved = 0;
        en = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (step !== 1'b0) step_seen++;
            if (occ !== snap) occ_moved++;
        end
        checks++; if (step_seen !== 0) $display("[TB] FAIL freeze_step: got %0d pulses expected 0", step_seen); else passed++;
        checks++; if (occ_moved !== 0) $display("[TB] FAIL freeze_occ: got %0d changes expected 0", occ_moved); else passed++;
        en = 1'b1;
        wait_step(n);
        checks++; if (n !== 6) $display("[TB] FAIL freeze_delay: got %0d expected 6", n); else passed++;
    endtask

    task automatic test_hit_query;
        logic [3:0] t_lane [10] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd0, 4'd0, 4'd15};
        logic [4:0] t_col  [10] = '{5'd1, 5'd2, 5'd0, 5'd0, 5'd7, 5'd1, 5'd0, 5'd9, 5'd8, 5'd31};
        logic       t_exp  [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        en = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            q_lane = t_lane[i];
            q_col  = t_col[i];
            @(negedge clk);
            checks++;
            if (hit !== t_exp[i] || hit !== m_hit)
                $display("[TB] FAIL hit_query_%0d_%0d: got %b expected %b", t_lane[i], t_col[i], hit, t_exp[i]);
            else passed++;
        end
        en = 1'b1;
    endtask

    task automatic test_load_vs_tick;
        int n;
        rst_n = 1'b0; level = 5'd0; en = 1'b1; load = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_step(n);
        checks++; if (occ !== 16'h8106) $display("[TB] FAIL load_pre_occ: got %h expected %h", occ, 16'h8106); else passed++;
        repeat (9) @(negedge clk);
        q_lane = 4'd0; q_col = 5'd0;
        load = 1'b1;
        @(negedge clk);
        checks++; if (occ !== 16'h8103) $display("[TB] FAIL load_occ: got %h expected %h", occ, 16'h8103); else passed++;
        checks++; if (step !== 1'b0) $display("[TB] FAIL load_step: got %b expected 0", step); else passed++;
        checks++; if (hit !== 1'b0) $display("[TB] FAIL load_hit: got %b expected 0", hit); else passed++;
        load = 1'b0;
        wait_step(n);
        checks++; if (n !== 10) $display("[TB] FAIL load_next_tick: got %0d expected 10", n); else passed++;
    endtask

    task automatic test_async_reset;
        int n;
        q_lane = 4'd1; q_col = 5'd0;
        for (int i = 0; i < 3; i++) begin
            wait_step(n);
            checks++; if (n !== 10) $display("[TB] FAIL pre_reset_tick_%0d: got %0d expected 10", i, n); else passed++;
        end
        q_lane = 4'd0; q_col = 5'd4;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (occ !== 16'h8103) $display("[TB] FAIL async_occ: got %h expected %h", occ, 16'h8103); else passed++;
        checks++; if (hit !== 1'b0) $display("[TB] FAIL async_hit: got %b expected 0", hit); else passed++;
        checks++; if (step !== 1'b0) $display("[TB] FAIL async_step: got %b expected 0", step); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++; if (occ !== model_occ(m_ticks)) $display("[TB] FAIL rand_occ_%0d: got %h expected %h", i, occ, model_occ(m_ticks)); else passed++;
            checks++; if (step !== m_step) $display("[TB] FAIL rand_step_%0d: got %b expected %b", i, step, m_step); else passed++;
            checks++; if (hit !== m_hit) $display("[TB] FAIL rand_hit_%0d: got %b expected %b", i, hit, m_hit); else passed++;
            level  = ($urandom % 4 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            en     = ($urandom % 6) != 0;
            load   = ($urandom % 50) == 0;
            q_lane = 4'($urandom_range(0, 3));
            q_col  = 5'($urandom_range(0, 9));
        end
    endtask

    // Scenario sequence followed by the summary.
    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_level_scaling();
        test_freeze();
        test_hit_query();
        test_load_vs_tick();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
